s8_nibble_driver: RTL and testbench



---
 rtl/s8_nibble_driver.sv | 87 ++++++++
 tb/tb_s8_nibble_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/s8_nibble_driver.sv
// s8_nibble_driver: byte-to-nibble front/back end for the 4-bit serialized S8 datapath.
// A byte is driven high nibble first; the two result nibbles are reassembled into an output FIFO.
module s8_nibble_driver #(
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [3:0] sb_in,
    output logic       sb_mc_a,
    output logic       sb_mc_b,
    input  logic [3:0] sb_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, HI, LO} state_t;
    state_t           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [3:0]       sb_in_q, sb_in_d, res_hi_q, res_hi_d;
    logic [2:0]       tag_q, tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, infl_q, infl_d;
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [7:0]       mem_q [OUT_DEPTH];
    logic [7:0]       mem_d [OUT_DEPTH];
    logic [CNT_W:0]   used;
    logic             accept, push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // tag_q[0] marks the LO cycle itself; [1] and [2] are the result-nibble strobes
    always_comb begin
        used      = {1'b0, cnt_q} + {1'b0, infl_q};
        in_ready  = (state_q != HI) && (used < (CNT_W + 1)'(OUT_DEPTH));
        accept    = in_valid && in_ready;
        push      = tag_q[2];
        out_valid = cnt_q != '0;
        pop       = out_valid && out_ready;
        out_data  = mem_q[rd_q];
        sb_in     = sb_in_q;
        sb_mc_a   = ~tag_q[0];
        sb_mc_b   = tag_q[2];
        state_d   = (state_q == HI) ? LO : accept ? HI : IDLE;
        hold_d    = accept ? in_data : hold_q;
        sb_in_d   = (state_d == HI) ? hold_d[7:4] : (state_d == LO) ? hold_q[3:0] : 4'h0;
        tag_d     = {tag_q[1:0], state_d == LO};
        res_hi_d  = tag_q[1] ? sb_out : res_hi_q;
        infl_d    = infl_q + CNT_W'(accept) - CNT_W'(push);
        cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_d      = push ? inc(wr_q) : wr_q;
        rd_d      = pop ? inc(rd_q) : rd_q;
        mem_d     = mem_q;
        if (push) mem_d[wr_q] = {res_hi_q, sb_out};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            sb_in_q  <= '0;
            res_hi_q <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            infl_q   <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            sb_in_q  <= sb_in_d;
            res_hi_q <= res_hi_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            infl_q   <= infl_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_s8_nibble_driver.sv
// tb_s8_nibble_driver: drives s8_nibble_driver against a stub nibble datapath and a
// transaction-level reference (accept history, in-order result queue, outstanding-byte limit).
module tb_s8_nibble_driver;
    localparam int OUT_DEPTH = 2;
    logic       clk = 0, reset_n = 1, in_valid = 0, out_ready = 0;
    logic [7:0] in_data = 0;
    logic       in_ready, sb_mc_a, sb_mc_b, out_valid;
    logic [3:0] sb_in, sb_out;
    logic [7:0] out_data;

    s8_nibble_driver #(.OUT_DEPTH(OUT_DEPTH), .CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sb_in(sb_in), .sb_mc_a(sb_mc_a), .sb_mc_b(sb_mc_b),
        .sb_out(sb_out), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Stub datapath: forms a byte from the previous nibble and the mc_a=0 nibble, then
    // returns the table result high nibble next cycle and low nibble the cycle after.
    logic [7:0] sbox [256];
    logic [3:0] dp_prev;
    logic [7:0] dp_res;
    logic [1:0] dp_t;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_prev <= '0;
            dp_res  <= '0;
            dp_t    <= '0;
        end else begin
            dp_prev <= sb_in;
            dp_t    <= {dp_t[0], ~sb_mc_a};
            if (!sb_mc_a) dp_res <= sbox[{dp_prev, sb_in}];
        end
    end
    assign sb_out = dp_t[0] ? dp_res[7:4] : dp_t[1] ? dp_res[3:0] : 4'h0;

    int         total = 0, bad = 0, now = 0;
    int         n_acc = 0, n_pop = 0, obs_acc = 0, obs_pop = 0;
    logic [7:0] q_byte [$];
    int         q_cyc [$];
    logic       h_v [5];
    logic [7:0] h_b [5];
    logic       last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_model();
        q_byte.delete();
        q_cyc.delete();
        n_acc = 0; n_pop = 0; obs_acc = 0; obs_pop = 0; now = 0;
        for (int k = 0; k < 5; k++) begin
            h_v[k] = 0;
            h_b[k] = 0;
        end
    endtask

    // One clock cycle: drive, check everything at negedge, advance the reference.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r);
        logic       e_rdy, e_val, acc;
        logic [3:0] e_sb;
        in_valid = v; in_data = d; out_ready = r;
        @(negedge clk);
        e_rdy = !h_v[1] && (n_acc - n_pop < OUT_DEPTH);
        e_val = q_cyc.size() > 0 && q_cyc[0] + 5 <= now;
        e_sb  = h_v[1] ? h_b[1][7:4] : h_v[2] ? h_b[2][3:0] : 4'h0;
        chk("in_ready", in_ready, e_rdy);
        chk("out_valid", out_valid, e_val);
        if (e_val) chk("out_data", out_data, sbox[q_byte[0]]);
        chk("sb_in", sb_in, e_sb);
        chk("mc_a", sb_mc_a, !h_v[2]);
        chk("mc_b", sb_mc_b, h_v[4]);
        if (v && in_ready) obs_acc++;
        if (out_valid && r) obs_pop++;
        chk("outstanding_le_depth", obs_acc - obs_pop <= OUT_DEPTH, 1);
        acc = v && e_rdy;
        last_acc = acc;
        if (acc) begin
            q_byte.push_back(d);
            q_cyc.push_back(now);
            n_acc++;
        end
        if (e_val && r) begin
            void'(q_byte.pop_front());
            void'(q_cyc.pop_front());
            n_pop++;
        end
        for (int k = 4; k > 1; k--) begin
            h_v[k] = h_v[k-1];
            h_b[k] = h_b[k-1];
        end
        h_v[1] = acc;
        h_b[1] = d;
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic do_reset();
        reset_n = 0; in_valid = 0; out_ready = 0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sb_in", sb_in, 0);
        chk("rst_mc_a", sb_mc_a, 1);
        chk("rst_mc_b", sb_mc_b, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        clear_model();
    endtask

    task automatic send(input logic [7:0] b);
        for (int c = 0; c < 50; c++) begin
            cyc(1, b, 1);
            if (last_acc) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && q_byte.size() > 0; c++) cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 1);
        chk("drain_empty", q_byte.size(), 0);
    endtask

    initial begin
        int i, base, obase;
        logic [7:0] b;
        for (int k = 0; k < 256; k++) sbox[k] = 8'($urandom);
        clear_model();
        #1;
        do_reset();

        // single byte 0x3C accepted at cycle 10
        while (now < 10) cyc(0, 8'h00, 1);
        cyc(1, 8'h3C, 1);
        chk("single_acc", last_acc, 1);
        drain();
        chk("single_pop", n_pop, 1);

        // streaming 0x00..0xFF with in_valid held high
        base = n_pop;
        i = 0;
        for (int c = 0; c < 4000 && i < 256; c++) begin
            cyc(1, 8'(i), 1);
            if (last_acc) i++;
        end
        chk("stream_acc", i, 256);
        drain();
        chk("stream_pop", n_pop - base, 256);

        // backpressure: three bytes offered, only OUT_DEPTH accepted
        obase = obs_acc;
        b = 8'($urandom);
        for (int c = 0; c < 14; c++) begin
            cyc(1, b, 0);
            if (last_acc) b = 8'($urandom);
        end
        chk("bp_accepted", obs_acc - obase, 2);
        chk("bp_ready_low", in_ready, 0);
        drain();

        // isolated bytes with idle gaps of 1..3 cycles after LO
        for (int g = 1; g <= 3; g++) begin
            send(8'($urandom));
            cyc(0, 8'h00, 1);
            cyc(0, 8'h00, 1);
            repeat (g) cyc(0, 8'h00, 1);
        end
        drain();

        // reset at cycle a+3 of a transfer, then a fresh byte
        send(8'hA5);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 1);
        do_reset();
        cyc(0, 8'h00, 1);
        send(8'h5A);
        drain();
        chk("post_reset_pop", n_pop, 1);

        // random valid/ready traffic
        base = n_pop;
        i = 0;
        b = 8'($urandom);
        for (int c = 0; c < 40000 && i < 3000; c++) begin
            cyc(1'($urandom), b, 1'($urandom));
            if (last_acc) begin
                i++;
                b = 8'($urandom);
            end
        end
        chk("rand_acc", i, 3000);
        drain();
        chk("rand_pop", n_pop - base, 3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
